// File: rtl/search_capture_pkg.sv
// Shared defaults and helpers for the search capture FIFO slice.
package search_capture_pkg;

   localparam int DEF_WIDTH = 3;   // {out_unconst, out2, out1}
   localparam int DEF_DEPTH = 4;   // power of two, at least 2
   localparam int DEF_CNT_W = 8;   // saturating overflow counter width

   typedef logic [DEF_WIDTH-1:0] sample_t;

   // Pointer width for a power-of-two deep array.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/search_capture_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset; the FIFO pointers define which entries are live.
module search_capture_ram
   import search_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = ptr_w(DEF_DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write the addressed entry on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/search_capture_fifo.sv
// Captures datapath samples on a strobe into a first-word-fall-through FIFO,
// presents them on a valid/ready port and counts samples dropped while full.
//
// Handshake: a transfer (pop) happens in a cycle where out_valid and out_ready
// are both high at the rising edge. out_valid depends only on registered
// occupancy, never on out_ready, and out_data is held stable while out_valid
// is high and out_ready is low.
module search_capture_fifo
   import search_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sample_en,
   input  logic [WIDTH-1:0]             d_in,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic [CNT_W-1:0]             overflow_cnt
);

   localparam int AW = ptr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] head;
   logic             push;
   logic             pop;
   logic             drop;

   // Flags come straight from the occupancy register so they can never disagree with it.
   always_comb begin
      full      = (count == CW'(DEPTH));
      empty     = (count == '0);
      out_valid = ~empty;
      out_data  = out_valid ? head : '0;
   end

   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   always_comb begin
      pop  = out_valid & out_ready;
      push = sample_en & (~full | pop);
      drop = sample_en & full & ~pop;
   end

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Occupancy moves only when exactly one of push/pop happens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Dropped-sample counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_cnt <= '0;
      end else if (drop && (overflow_cnt != '1)) begin
         overflow_cnt <= overflow_cnt + CNT_W'(1);
      end
   end

   search_capture_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (d_in),
      .raddr (rd_ptr),
      .rdata (head)
   );

endmodule

// File: tb/tb_search_capture_fifo.sv
// Directed bench for search_capture_fifo (WIDTH=3, DEPTH=4, CNT_W=8).
module tb_search_capture_fifo;

   logic       clk;
   logic       rst_n;
   logic       sample_en;
   logic [2:0] d_in;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out_data;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic [7:0] overflow_cnt;

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];

   search_capture_fifo #(.WIDTH(3), .DEPTH(4), .CNT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_en    (sample_en),
      .d_in         (d_in),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow_cnt (overflow_cnt)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sample_en = 1'b0; d_in = '0; out_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      repeat (5) step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (out_data !== 3'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
      checks++; if (overflow_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); end
   endtask

   task automatic test_basic();
      logic [2:0] vec [3];
      vec[0] = 3'b001; vec[1] = 3'b010; vec[2] = 3'b100;
      // Empty FIFO with out_ready high: push only, first sample visible next cycle.
      out_ready = 1'b1;
      sample_en = 1'b1; d_in = vec[0];
      step();
      out_ready = 1'b0;
      checks++; if (out_data !== 3'b001) begin errors++; $display("FAIL basic_fwft: got %0d expected 1", out_data); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", count); end
      for (int i = 1; i < 3; i++) begin
         d_in = vec[i];
         step();
      end
      sample_en = 1'b0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL basic_count3: got %0d expected 3", count); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_data !== vec[i]) begin errors++; $display("FAIL basic_drain%0d: got %0d expected %0d", i, out_data, vec[i]); end
         step();
      end
      out_ready = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %0b expected 1", empty); end
      checks++; if (out_data !== 3'd0) begin errors++; $display("FAIL basic_data0: got %0d expected 0", out_data); end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         sample_en = 1'b1; d_in = 3'(i);
         step();
         if (i == 3) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_notfull3: got %0b expected 0", full); end
         end
         if (i == 4) begin
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full4: got %0b expected 1", full); end
         end
      end
      sample_en = 1'b0;
      checks++; if (overflow_cnt !== 8'd2) begin errors++; $display("FAIL ovf_cnt: got %0d expected 2", overflow_cnt); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (out_data !== 3'(i)) begin errors++; $display("FAIL ovf_drain%0d: got %0d expected %0d", i, out_data, i); end
         step();
      end
      out_ready = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %0b expected 1", empty); end
   endtask

   task automatic test_full_stream();
      exp_q.delete();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         sample_en = 1'b1; d_in = 3'(i);
         exp_q.push_back(3'(i));
         step();
      end
      // Simultaneous push and pop while full: occupancy holds, nothing dropped.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d_in = 3'(i);
         checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL stream_out%0d: got %0d expected %0d", i, out_data, exp_q[0]); end
         void'(exp_q.pop_front());
         exp_q.push_back(3'(i));
         step();
         checks++; if (count !== 3'd4) begin errors++; $display("FAIL stream_count%0d: got %0d expected 4", i, count); end
      end
      sample_en = 1'b0;
      checks++; if (overflow_cnt !== 8'd2) begin errors++; $display("FAIL stream_ovf: got %0d expected 2", overflow_cnt); end
      while (exp_q.size() > 0) begin
         checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL stream_tail: got %0d expected %0d", out_data, exp_q[0]); end
         void'(exp_q.pop_front());
         step();
      end
      out_ready = 1'b0;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %0b expected 1", empty); end
   endtask

   task automatic test_saturate();
      out_ready = 1'b0;
      sample_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d_in = 3'(i);
         step();
      end
      // Counter starts at 2; 252 drops reach 254, the next one reaches 255.
      repeat (252) step();
      checks++; if (overflow_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", overflow_cnt); end
      step();
      checks++; if (overflow_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", overflow_cnt); end
      repeat (47) step();
      checks++; if (overflow_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", overflow_cnt); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL sat_count: got %0d expected 4", count); end
      sample_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      step(); step();
      out_ready = 1'b0;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL mid_count2: got %0d expected 2", count); end
      // Assert reset between edges: outputs must clear without a clock edge.
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %0b expected 0", out_valid); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count_async: got %0d expected 0", count); end
      checks++; if (overflow_cnt !== 8'd0) begin errors++; $display("FAIL mid_ovf_async: got %0d expected 0", overflow_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count_rel: got %0d expected 0", count); end
      sample_en = 1'b1; d_in = 3'b101;
      step();
      sample_en = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_new: got %0b expected 1", out_valid); end
      checks++; if (out_data !== 3'b101) begin errors++; $display("FAIL mid_data_new: got %0d expected 5", out_data); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_count_new: got %0d expected 1", count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_stream();
      test_saturate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/search_capture_fifo.md
Name: search_capture_fifo

Overview:
- Downstream consumer of the timing-check test datapath.
- Samples the registered outputs (out1, out2, out_unconst) on a strobe and buffers them in a small first-word-fall-through FIFO.
- Presents buffered samples on a valid/ready port and counts samples dropped while the FIFO is full.
- Single clock domain (clk); gives the STA test suite a second sequential stage with handshake, pointer and counter logic.

Parameters:
- WIDTH, 3, bits per sample: {out_unconst, out2, out1}.
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_en  input  1  push request for d_in this cycle.
- d_in  input  WIDTH  sample data.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  FIFO non-empty; out_data is valid.
- out_data  output  WIDTH  head entry; 0 when empty.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow_cnt  output  CNT_W  saturating count of dropped samples.

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk release):
  - wr_ptr, rd_ptr, count and overflow_cnt are 0.
  - out_valid is 0, empty is 1, full is 0, out_data is 0.
  - Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Definitions:
  - pop = out_valid & out_ready.
  - push = sample_en & (~full | pop).
  - drop = sample_en & full & ~pop.
- On push: mem[wr_ptr] <= d_in and wr_ptr increments.
- On pop: rd_ptr increments.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Output timing:
  - out_valid, full and empty derive combinationally from registered count.
  - out_data = mem[rd_ptr] combinationally when out_valid, else 0 (first-word fall-through).
  - A sample pushed in cycle N is visible on out_data in cycle N+1.
- Boundary cases:
  - Empty with sample_en and out_ready both high: out_valid is 0, so there is no pop; push only. Next cycle count = 1.
  - Full with sample_en and pop: both occur, count stays DEPTH, no drop.
  - Full with sample_en and no pop: sample discarded; overflow_cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - out_ready high while empty: no effect.
  - Reset mid-operation: all contents are logically discarded and the outputs listed under Reset return to their reset values immediately, without waiting for a clk edge.
- No internal state machine beyond the occupancy counter; status flags are not separately registered, so flags can never disagree with count.

Decomposition:
- Package search_capture_pkg:
  - default WIDTH/DEPTH/CNT_W localparams;
  - function ptr_w(depth) returning $clog2(depth);
  - typedef sample_t = logic [WIDTH-1:0].
- One sub-module, search_capture_ram: DEPTH x WIDTH array, single synchronous write port (we, waddr, wdata), asynchronous read port (raddr, rdata). All pointer, count and overflow logic stays in search_capture_fifo.

Test Plan:
- Reset then idle 5 cycles: out_valid=0, empty=1, full=0, count=0, out_data=0, overflow_cnt=0.
- Push 3'b001, 3'b010, 3'b100 on consecutive cycles with out_ready=0 -> count=3; then out_ready=1 -> out_data reads 001, 010, 100 on three consecutive cycles, then empty=1.
- Push 6 samples (1..6) with out_ready=0 -> full=1 after the 4th; overflow_cnt=2; drain yields 1,2,3,4.
- Full FIFO, sample_en=1 and out_ready=1 for 8 cycles with d_in=0..7 -> count stays 4, overflow_cnt unchanged, output stream continuous and in order. Wrap-around is exercised twice.
- Hold full with sample_en=1 and out_ready=0 for 300 cycles -> overflow_cnt saturates at 255 and stays there.
- Assert rst_n=0 mid-stream with count=2 -> out_valid drops immediately; after release count=0 and a new push of 3'b101 appears as the first output.
